// File: rtl/ram_sp_cfg.sv
// ram_sp_cfg: single-port synchronous RAM for the 16-bit RISC datapath.
// Configurable width/depth, byte write enables, read-during-write mode,
// 1- or 2-cycle read latency, and a post-reset clear engine.
module ram_sp_cfg #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  parameter int CLR_EN   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              run_access;
  logic              rdw_hold;
  logic [NB-1:0]     wr_be;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_merge;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign busy       = (state_q == ST_CLEAR);
  assign run_access = !reset && (state_q == ST_RUN) && en;
  // In no-change mode a write access leaves the read slot exactly as it was.
  assign rdw_hold   = (RDW_MODE == 2) && (|be);
  assign mem_rdata  = mem[addr];

  // Clear engine next state: walk every address once, then hand over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  // FSM and clear pointer registers; reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLR_EN != 0) ? ST_CLEAR : ST_RUN;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Single write port shared by the clear engine and user writes.
  always_comb begin
    wr_be   = '0;
    wr_addr = addr;
    wr_data = din;
    if (!reset && (state_q == ST_CLEAR)) begin
      wr_be   = '1;
      wr_addr = clr_ptr_q;
      wr_data = INIT_VAL;
    end else if (run_access) begin
      wr_be   = be;
    end
  end

  // Array write with per-lane enables; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first mode forwards the enabled lanes of din; other modes show old data.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign rd_merge[8*gi +: 8] = ((RDW_MODE == 1) && be[gi]) ? din[8*gi +: 8]
                                                                : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Array output register: first read pipeline slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (!run_access) begin
      rd_valid_q <= 1'b0;
    end else if (!rdw_hold) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_merge;
    end
  end

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
      $error("ram_sp_cfg: DATA_W must be a positive multiple of 8");
    end

    if (RD_LAT == 1) begin : g_lat1
      assign dout   = rd_data_q;
      assign rvalid = rd_valid_q;
    end else if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_data_q;
      logic              out_valid_q;

      // Extra output register; data only advances with a valid slot so dout holds when idle.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) begin
            out_data_q <= rd_data_q;
          end
        end
      end

      assign dout   = out_data_q;
      assign rvalid = out_valid_q;
    end else begin : g_bad_lat
      $error("ram_sp_cfg: RD_LAT must be 1 or 2");
      assign dout   = '0;
      assign rvalid = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_cfg.sv
// Testbench for ram_sp_cfg: three instances share one stimulus stream.
//   dut 0: 16x16,  RD_LAT=1, read-first,  clear to A5A5
//   dut 1: 256x16, RD_LAT=2, write-first, clear to 0000
//   dut 2: 256x16, RD_LAT=1, no-change,   no clear engine
// Stimulus pushes expected responses into per-instance queues; a negedge
// monitor pops them whenever rvalid is seen.
module tb_ram_sp_cfg;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] m;
    logic [31:0] cyc;
  } exp_t;

  localparam int           LAT   [3] = '{1, 2, 1};
  localparam int           MODE  [3] = '{0, 1, 2};
  localparam int           DEPTH [3] = '{16, 256, 256};
  localparam int           CLR   [3] = '{1, 1, 0};
  localparam logic [15:0]  INITV [3] = '{16'hA5A5, 16'h0000, 16'h0000};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout [3];
  logic        rvalid [3];
  logic        busy [3];

  logic [31:0] cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t        q [3][$];
  exp_t        mon_e;
  logic [15:0] mm [3][256];
  logic [1:0]  kn [3][256];
  logic        pv [3];
  logic [15:0] pd [3];
  logic [1:0]  pk [3];
  int          bcnt [3];
  int          ptr [3];
  logic        busy_s [3];
  logic [15:0] lastpop [3];
  logic        started = 1'b0;
  logic        last_r = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram_sp_cfg #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .CLR_EN(1),
               .INIT_VAL(16'hA5A5)) dut_a (
    .clk(clk), .reset(reset), .en(en), .be(be), .addr(addr[3:0]), .din(din),
    .dout(dout[0]), .rvalid(rvalid[0]), .busy(busy[0]));

  ram_sp_cfg #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .RDW_MODE(1), .CLR_EN(1),
               .INIT_VAL(16'h0000)) dut_b (
    .clk(clk), .reset(reset), .en(en), .be(be), .addr(addr), .din(din),
    .dout(dout[1]), .rvalid(rvalid[1]), .busy(busy[1]));

  ram_sp_cfg #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1), .RDW_MODE(2), .CLR_EN(0),
               .INIT_VAL(16'h0000)) dut_c (
    .clk(clk), .reset(reset), .en(en), .be(be), .addr(addr), .din(din),
    .dout(dout[2]), .rvalid(rvalid[2]), .busy(busy[2]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Reference behaviour of one instance for the edge that samples these inputs.
  task automatic model(input int k, input logic r, input logic e, input logic [1:0] b,
                       input logic [7:0] a, input logic [15:0] d);
    int ai;
    logic [15:0] rd;
    logic [1:0]  rk;
    exp_t        x;
    ai = (k == 0) ? int'(a[3:0]) : int'(a);
    if (r) begin
      while (q[k].size() > 0 && q[k][$].cyc > cyc) void'(q[k].pop_back());
      pv[k] = 1'b0; pd[k] = 16'h0000; pk[k] = 2'b11;
      bcnt[k] = (CLR[k] != 0) ? DEPTH[k] : 0;
      ptr[k] = 0;
    end else if (bcnt[k] > 0) begin
      mm[k][ptr[k]] = INITV[k];
      kn[k][ptr[k]] = 2'b11;
      ptr[k]++;
      bcnt[k]--;
      pv[k] = 1'b0;
    end else if (!e) begin
      pv[k] = 1'b0;
    end else begin
      rd = mm[k][ai];
      rk = kn[k][ai];
      if (MODE[k] == 1) begin
        if (b[0]) begin rd[7:0]  = d[7:0];  rk[0] = 1'b1; end
        if (b[1]) begin rd[15:8] = d[15:8]; rk[1] = 1'b1; end
      end
      if (!(MODE[k] == 2 && b != 2'b00)) begin
        pv[k] = 1'b1; pd[k] = rd; pk[k] = rk;
      end
      if (b[0]) begin mm[k][ai][7:0]  = d[7:0];  kn[k][ai][0] = 1'b1; end
      if (b[1]) begin mm[k][ai][15:8] = d[15:8]; kn[k][ai][1] = 1'b1; end
    end
    if (pv[k]) begin
      x.d = pd[k];
      x.m = {{8{pk[k][1]}}, {8{pk[k][0]}}};
      x.cyc = cyc + 32'(LAT[k]);
      q[k].push_back(x);
    end
  endtask

  // One clock cycle of stimulus; also checks busy and post-reset output state.
  task automatic step(input logic r, input logic e, input logic [1:0] b,
                      input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      busy_s[k] = busy[k];
      if (started) chk($sformatf("busy_dut%0d_cyc%0d", k, cyc), {15'b0, busy[k]},
                       {15'b0, (bcnt[k] > 0)});
      if (last_r) begin
        chk($sformatf("reset_dout_dut%0d", k), dout[k], 16'h0000);
        chk($sformatf("reset_rvalid_dut%0d", k), {15'b0, rvalid[k]}, 16'h0000);
      end
    end
    reset = r; en = e; be = b; addr = a; din = d;
    for (int k = 0; k < 3; k++) model(k, r, e, b, a, d);
    last_r = r;
    if (r) started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000);
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] b, input logic [15:0] d);
    step(1'b0, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b1, 2'b00, a, 16'h0000);
  endtask

  // Monitor: pop and compare whenever a DUT presents rvalid.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
        mon_e = q[k].pop_front();
        checks++;
        errors++;
        $display("FAIL missing_read dut%0d: no rvalid at cyc %0d, required data %h", k, mon_e.cyc, mon_e.d);
      end
      if (rvalid[k] === 1'b1) begin
        checks++;
        if (q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid dut%0d cyc %0d: got dout %h, required no output", k, cyc, dout[k]);
        end else begin
          mon_e = q[k].pop_front();
          if (mon_e.cyc != cyc || ((dout[k] ^ mon_e.d) & mon_e.m) != 16'h0000) begin
            errors++;
            $display("FAIL read_data dut%0d: got %h at cyc %0d, required %h at cyc %0d",
                     k, dout[k], cyc, mon_e.d, mon_e.cyc);
          end
        end
        lastpop[k] = dout[k];
      end
    end
  end

  initial begin
    int bc;
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0; pd[k] = 16'h0; pk[k] = 2'b11; bcnt[k] = 0; ptr[k] = 0;
      lastpop[k] = 16'h0;
      for (int i = 0; i < 256; i++) begin mm[k][i] = 16'h0; kn[k][i] = 2'b00; end
    end

    // Reset, then partial clear with en pulses that must be ignored.
    step(1'b1, 1'b0, 2'b00, 8'h00, 16'h0);
    step(1'b1, 1'b0, 2'b00, 8'h00, 16'h0);
    for (int i = 0; i < 7; i++) step(1'b0, i[0], 2'b11, 8'h02, 16'h0BAD);

    // Reset mid-clear: dut 0 must stay busy for a full 16 more cycles.
    step(1'b1, 1'b0, 2'b00, 8'h00, 16'h0);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i < 14) && (i % 3 == 0), 2'b11, 8'h05, 16'hDEAD);
      if (busy_s[0]) bc++;
    end
    chk("busy_cycles_dut0", 16'(bc), 16'd16);

    idle(250);
    chk("clear_done_dut1", {15'b0, busy[1]}, 16'h0000);

    // Clear contents: every location of dut 0 reads A5A5.
    for (int i = 0; i < 16; i++) rd(8'(i));
    idle(3);
    chk("clear_val_dut0", lastpop[0], 16'hA5A5);

    // Latency.
    wr(8'h10, 2'b11, 16'h1234);
    idle(1);
    rd(8'h10);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("latency_dut%0d", k), lastpop[k], 16'h1234);

    // Byte lanes.
    wr(8'h20, 2'b11, 16'hFFFF);
    wr(8'h20, 2'b01, 16'h00AB);
    rd(8'h20);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("lane_lo_dut%0d", k), lastpop[k], 16'hFFAB);
    wr(8'h20, 2'b10, 16'hCD00);
    rd(8'h20);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("lane_hi_dut%0d", k), lastpop[k], 16'hCDAB);

    // Read-during-write.
    wr(8'h03, 2'b11, 16'h1111);
    idle(1);
    wr(8'h03, 2'b11, 16'h2222);
    idle(3);
    chk("rdw_read_first", lastpop[0], 16'h1111);
    chk("rdw_write_first", lastpop[1], 16'h2222);
    chk("rdw_no_change", dout[2], 16'hCDAB);
    rd(8'h03);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("rdw_after_dut%0d", k), lastpop[k], 16'h2222);

    // Top address and full throughput.
    wr(8'h00, 2'b11, 16'h0F0F);
    wr(8'hFF, 2'b11, 16'hF0F0);
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: wr(8'hFF, 2'b11, 16'h1000 + 16'(i));
        1: rd(8'h00);
        2: wr(8'h00, 2'b11, 16'h1000 + 16'(i));
        default: rd(8'hFF);
      endcase
    end
    rd(8'h00);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("addr00_dut%0d", k), lastpop[k], 16'h1012);
    rd(8'hFF);
    idle(3);
    for (int k = 0; k < 3; k++) chk($sformatf("addrFF_dut%0d", k), lastpop[k], 16'h1010);

    idle(4);
    for (int k = 0; k < 3; k++) chk($sformatf("queue_drained_dut%0d", k), 16'(q[k].size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
